// File: rtl/pit_bus_pkg.sv
// Shared encodings for the 8254 bus master: request ops, FSM states and
// control-word fields.
package pit_bus_pkg;

  localparam logic [1:0] OP_WR      = 2'd0;
  localparam logic [1:0] OP_RD      = 2'd1;
  localparam logic [1:0] OP_LOAD16  = 2'd2;
  localparam logic [1:0] OP_LATCH16 = 2'd3;

  localparam logic [1:0] ADDR_CWR   = 2'b11;
  localparam logic [1:0] RW_LATCH   = 2'b00;
  localparam logic [1:0] RW_LSB_MSB = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StGap,
    StResp
  } pit_state_e;

  // Control word layout: SC1 SC0 RW1 RW0 M2 M1 M0 BCD.
  function automatic logic [7:0] pit_cw(input logic [1:0] sc, input logic [1:0] rw,
                                        input logic [2:0] mode, input logic bcd);
    return {sc, rw, mode, bcd};
  endfunction

endpackage

// File: rtl/pit_bus_cycle.sv
// Single byte-cycle timing engine: SETUP, STROBE and HOLD phases with read
// capture on the final strobe edge. Starts one cycle after start_i is seen idle.
module pit_bus_cycle
  import pit_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [1:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] data_in_i,
  output logic       done_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a1_o,
  output logic       a0_o,
  output logic [7:0] data_out_o,
  output logic       data_oe_o,
  output logic [7:0] rdata_o
);

  pit_state_e state_q;
  logic [7:0] cnt_q;
  logic       we_q;
  logic       cs_n_q, rd_n_q, wr_n_q, oe_q;
  logic [1:0] addr_q;
  logic [7:0] dout_q, rdata_q;

  // Phase sequencing with registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= 2'b00;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StSetup;
            cnt_q   <= 8'd0;
            we_q    <= we_i;
            cs_n_q  <= 1'b0;
            addr_q  <= addr_i;
            dout_q  <= we_i ? wdata_i : 8'h00;
            oe_q    <= we_i;
          end
        end
        StSetup: begin
          if (cnt_q == 8'(SETUP_CYC - 1)) begin
            state_q <= StStrobe;
            cnt_q   <= 8'd0;
            wr_n_q  <= ~we_q;
            rd_n_q  <= we_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StStrobe: begin
          if (cnt_q == 8'(STROBE_CYC - 1)) begin
            state_q <= StHold;
            cnt_q   <= 8'd0;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            if (!we_q) rdata_q <= data_in_i;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (cnt_q == 8'(HOLD_CYC - 1)) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Done flags the last HOLD cycle so the sequencer can react on the same edge.
  assign done_o     = (state_q == StHold) && (cnt_q == 8'(HOLD_CYC - 1));
  assign cs_n_o     = cs_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
  assign a1_o       = addr_q[1];
  assign a0_o       = addr_q[0];
  assign data_out_o = dout_q;
  assign data_oe_o  = oe_q;
  assign rdata_o    = rdata_q;

endmodule

// File: rtl/pit_bus_master.sv
// Request sequencer for the 8254 bus: accepts one command, issues 1 or 3 byte
// cycles through pit_bus_cycle and returns a single-cycle response.
module pit_bus_master
  import pit_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_addr,
  input  logic [2:0]  req_mode,
  input  logic        req_bcd,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        a1,
  output logic        a0,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  // StSetup here means "a byte cycle is in flight in the engine".
  pit_state_e  state_q;
  logic        req_ready_q, start_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [15:0] rsp_data_q;
  logic [1:0]  op_q, addr_q, idx_q;
  logic [2:0]  mode_q;
  logic        bcd_q;
  logic [15:0] data_q;
  logic [7:0]  lsb_q;

  logic        cyc_we, cyc_done, last_byte;
  logic [1:0]  cyc_addr;
  logic [7:0]  cyc_wdata, cyc_rdata;

  // Select address/direction/data of the current byte within the op.
  always_comb begin
    cyc_we    = 1'b1;
    cyc_addr  = addr_q;
    cyc_wdata = data_q[7:0];
    case (op_q)
      OP_RD: cyc_we = 1'b0;
      OP_LOAD16: begin
        if (idx_q == 2'd0) begin
          cyc_addr  = ADDR_CWR;
          cyc_wdata = pit_cw(addr_q, RW_LSB_MSB, mode_q, bcd_q);
        end else if (idx_q == 2'd2) begin
          cyc_wdata = data_q[15:8];
        end
      end
      OP_LATCH16: begin
        if (idx_q == 2'd0) begin
          cyc_addr  = ADDR_CWR;
          cyc_wdata = pit_cw(addr_q, RW_LATCH, 3'b000, 1'b0);
        end else begin
          cyc_we    = 1'b0;
          cyc_wdata = 8'h00;
        end
      end
      default: ;
    endcase
  end

  assign last_byte = (op_q == OP_WR) || (op_q == OP_RD) || (idx_q == 2'd2);

  // Command sequencer with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 16'h0000;
      op_q        <= OP_WR;
      addr_q      <= 2'b00;
      idx_q       <= 2'd0;
      mode_q      <= 3'b000;
      bcd_q       <= 1'b0;
      data_q      <= 16'h0000;
      lsb_q       <= 8'h00;
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            op_q        <= req_op;
            addr_q      <= req_addr;
            mode_q      <= req_mode;
            bcd_q       <= req_bcd;
            data_q      <= req_data;
            idx_q       <= 2'd0;
            // Counter select 3 is the control register itself: reject.
            if ((req_op == OP_LOAD16 || req_op == OP_LATCH16) && req_addr == ADDR_CWR) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 16'h0000;
            end else begin
              state_q <= StSetup;
              start_q <= 1'b1;
            end
          end
        end
        StSetup: begin
          if (cyc_done) begin
            if (last_byte) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              if (op_q == OP_RD)           rsp_data_q <= {8'h00, cyc_rdata};
              else if (op_q == OP_LATCH16) rsp_data_q <= {cyc_rdata, lsb_q};
              else                         rsp_data_q <= 16'h0000;
            end else begin
              state_q <= StGap;
              start_q <= 1'b1;
              idx_q   <= idx_q + 2'd1;
              if (idx_q == 2'd1) lsb_q <= cyc_rdata;
            end
          end
        end
        StGap: state_q <= StSetup;
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pit_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cycle (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start_q),
    .we_i      (cyc_we),
    .addr_i    (cyc_addr),
    .wdata_i   (cyc_wdata),
    .data_in_i (data_in),
    .done_o    (cyc_done),
    .cs_n_o    (cs_n),
    .rd_n_o    (rd_n),
    .wr_n_o    (wr_n),
    .a1_o      (a1),
    .a0_o      (a0),
    .data_out_o(data_out),
    .data_oe_o (data_oe),
    .rdata_o   (cyc_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pit_bus_master.sv
// Bench for pit_bus_master: a default build and a STROBE_CYC=4 build share the
// request inputs; each has its own bus trace checked against a window model.
module tb_pit_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'd0, req_addr = 2'd0;
  logic [2:0]  req_mode = 3'd0;
  logic        req_bcd = 1'b0;
  logic [15:0] req_data = 16'h0;

  logic        req_ready[2], rsp_valid[2], rsp_err[2];
  logic [15:0] rsp_data[2];
  logic        cs_n[2], rd_n[2], wr_n[2], a1[2], a0[2], data_oe[2];
  logic [7:0]  data_out[2], data_in[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pit_bus_master u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op(req_op), .req_addr(req_addr), .req_mode(req_mode), .req_bcd(req_bcd),
    .req_data(req_data), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]),
    .rsp_data(rsp_data[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
    .a1(a1[0]), .a0(a0[0]), .data_out(data_out[0]), .data_oe(data_oe[0]),
    .data_in(data_in[0])
  );

  pit_bus_master #(.STROBE_CYC(4)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op(req_op), .req_addr(req_addr), .req_mode(req_mode), .req_bcd(req_bcd),
    .req_data(req_data), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]),
    .rsp_data(rsp_data[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
    .a1(a1[1]), .a0(a0[1]), .data_out(data_out[1]), .data_oe(data_oe[1]),
    .data_in(data_in[1])
  );

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] data;
    logic [7:0]  rv0;
    logic [7:0]  rv1;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[8];

  function automatic int strb(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int bsize(input int d);
    return 1 + strb(d) + 1;
  endfunction

  function automatic int nbytes(input logic [1:0] op, input logic [1:0] addr);
    if (op == 2'd2 || op == 2'd3) return (addr == 2'd3) ? 0 : 3;
    return 1;
  endfunction

  // Byte b of a request: bus address, direction and write data.
  function automatic void get_byte(input logic [1:0] op, input logic [1:0] addr,
                                   input logic [2:0] mode, input logic bcd,
                                   input logic [15:0] data, input int b,
                                   output logic [1:0] ba, output logic bwe,
                                   output logic [7:0] bd);
    ba = addr; bwe = 1'b1; bd = data[7:0];
    case (op)
      2'd1: begin bwe = 1'b0; bd = 8'h00; end
      2'd2: begin
        if (b == 0) begin ba = 2'd3; bd = {addr, 2'b11, mode, bcd}; end
        else if (b == 2) bd = data[15:8];
      end
      2'd3: begin
        if (b == 0) begin ba = 2'd3; bd = {addr, 6'b000000}; end
        else begin bwe = 1'b0; bd = 8'h00; end
      end
      default: ;
    endcase
  endfunction

  // Expected {cs_n,rd_n,wr_n,a1,a0,oe,dout} for period t after the accept edge.
  function automatic void exp_bus(input int d, input int t, input logic [1:0] op,
                                  input logic [1:0] addr, input logic [2:0] mode,
                                  input logic bcd, input logic [15:0] data,
                                  output logic [13:0] want, output logic [13:0] mask);
    logic [1:0] ba;
    logic       bwe, sact;
    logic [7:0] bd;
    int         s;
    want = {3'b111, 2'b00, 1'b0, 8'h00};
    mask = 14'h3900;
    for (int b = 0; b < nbytes(op, addr); b++) begin
      s = 1 + b * (bsize(d) + 1);
      if (t >= s && t <= s + bsize(d) - 1) begin
        get_byte(op, addr, mode, bcd, data, b, ba, bwe, bd);
        sact = (t >= s + 1) && (t <= s + strb(d));
        want = {1'b0, ~(sact & ~bwe), ~(sact & bwe), ba, bwe, bwe ? bd : 8'h00};
        mask = bwe ? 14'h3FFF : 14'h3F00;
      end
    end
  endfunction

  // Value to place on data_in: the intended byte on the last strobe period of
  // each read, noise everywhere else.
  function automatic logic [7:0] din_for(input int d, input int t, input logic [1:0] op,
                                         input logic [1:0] addr, input logic [7:0] rv0,
                                         input logic [7:0] rv1, input logic [7:0] noise);
    int s;
    for (int b = 0; b < nbytes(op, addr); b++) begin
      s = 1 + b * (bsize(d) + 1);
      if (t == s + strb(d)) begin
        if (op == 2'd1) return rv0;
        if (op == 2'd3 && b == 1) return rv0;
        if (op == 2'd3 && b == 2) return rv1;
      end
    end
    return noise;
  endfunction

  function automatic logic [16:0] rsp_model(input logic [1:0] op, input logic [1:0] addr,
                                            input logic [7:0] rv0, input logic [7:0] rv1);
    if (nbytes(op, addr) == 0) return {1'b1, 16'h0000};
    if (op == 2'd1) return {1'b0, 8'h00, rv0};
    if (op == 2'd3) return {1'b0, rv1, rv0};
    return 17'h0;
  endfunction

  task automatic chk(input string nm, input int d, input int t, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0d got %h want %h", nm, d, t, got, want);
    end
  endtask

  // Called mid-period; returns mid-period after both builds are idle again.
  task automatic run_txn(input logic [1:0] op, input logic [1:0] addr, input logic [2:0] mode,
                         input logic bcd, input logic [15:0] data, input logic [7:0] rv0,
                         input logic [7:0] rv1, input logic [15:0] exp_d, input logic exp_e,
                         input logic noise);
    int         rt[2];
    int         tmax, tmin;
    logic [13:0] want, mask, got;
    for (int d = 0; d < 2; d++)
      rt[d] = (nbytes(op, addr) == 0) ? 0 : nbytes(op, addr) * (bsize(d) + 1);
    tmax = ((rt[0] > rt[1]) ? rt[0] : rt[1]) + 1;
    tmin = (rt[0] < rt[1]) ? rt[0] : rt[1];
    req_valid = 1'b1; req_op = op; req_addr = addr; req_mode = mode;
    req_bcd = bcd; req_data = data;
    @(posedge clk);
    for (int t = 0; t <= tmax; t++) begin
      #1;
      req_valid = noise && (t <= tmin);
      req_op    = 2'($urandom_range(0, 3));
      req_addr  = 2'($urandom_range(0, 3));
      req_mode  = 3'($urandom_range(0, 7));
      req_bcd   = 1'($urandom_range(0, 1));
      req_data  = 16'($urandom);
      for (int d = 0; d < 2; d++) begin
        exp_bus(d, t, op, addr, mode, bcd, data, want, mask);
        got = {cs_n[d], rd_n[d], wr_n[d], a1[d], a0[d], data_oe[d], data_out[d]};
        chk("bus", d, t, 32'(got & mask), 32'(want & mask));
        chk("rsp_valid", d, t, 32'(rsp_valid[d]), 32'(t == rt[d]));
        chk("req_ready", d, t, 32'(req_ready[d]), 32'(t > rt[d]));
        if (t == rt[d]) chk("rsp", d, t, {15'h0, rsp_err[d], rsp_data[d]}, {15'h0, exp_e, exp_d});
        data_in[d] = din_for(d, t, op, addr, rv0, rv1, 8'($urandom));
      end
      if (t < tmax) @(posedge clk);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    for (int d = 0; d < 2; d++)
      chk(nm, d, 0,
          {6'h0, cs_n[d], rd_n[d], wr_n[d], a1[d], a0[d], data_oe[d], data_out[d],
           rsp_valid[d], rsp_err[d], req_ready[d], rsp_data[d][4:0]},
          {6'h0, 3'b111, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'h0});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op, addr;
    logic [7:0]  rv0, rv1;
    logic [15:0] dat;
    logic [16:0] m;

    tbl[0] = '{2'd0, 2'd1, 3'd0, 1'b0, 16'h00A5, 8'h00, 8'h00, 16'h0000, 1'b0};
    tbl[1] = '{2'd2, 2'd2, 3'd3, 1'b0, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0};
    tbl[2] = '{2'd3, 2'd0, 3'd0, 1'b0, 16'h0000, 8'h78, 8'h56, 16'h5678, 1'b0};
    tbl[3] = '{2'd2, 2'd3, 3'd2, 1'b1, 16'hBEEF, 8'h00, 8'h00, 16'h0000, 1'b1};
    tbl[4] = '{2'd1, 2'd2, 3'd0, 1'b0, 16'h0000, 8'h3C, 8'h00, 16'h003C, 1'b0};
    tbl[5] = '{2'd3, 2'd3, 3'd0, 1'b0, 16'h0000, 8'h11, 8'h22, 16'h0000, 1'b1};
    tbl[6] = '{2'd1, 2'd3, 3'd0, 1'b0, 16'h0000, 8'hC3, 8'h00, 16'h00C3, 1'b0};
    tbl[7] = '{2'd2, 2'd0, 3'd5, 1'b1, 16'hFFFF, 8'h00, 8'h00, 16'h0000, 1'b0};

    data_in[0] = 8'h00;
    data_in[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("post_reset");

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].mode, tbl[i].bcd, tbl[i].data,
              tbl[i].rv0, tbl[i].rv1, tbl[i].exp_d, tbl[i].exp_e, 1'(i % 2));

    // Reset during the strobe of the second byte of a LOAD16.
    req_valid = 1'b1; req_op = 2'd2; req_addr = 2'd1; req_mode = 3'd2;
    req_bcd = 1'b0; req_data = 16'hCAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_strobe_wr_n", 0, 7, 32'(wr_n[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state("abort");
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++)
        chk("after_abort", d, t, {30'h0, cs_n[d], rsp_valid[d]}, {30'h0, 1'b1, 1'b0});
    end

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = 2'($urandom_range(0, 3));
      rv0  = 8'($urandom);
      rv1  = 8'($urandom);
      dat  = 16'($urandom);
      m    = rsp_model(op, addr, rv0, rv1);
      run_txn(op, addr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), dat,
              rv0, rv1, m[15:0], m[16], 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pit_bus_master.md
Name: pit_bus_master

Overview:
Host-side initiator that drives the 8254 timer's parallel bus (CS/RD/WR/A1/A0/Data) from a simple valid/ready command interface. It converts high-level requests into timed byte cycles on the timer bus. Requests are single byte read/write, 16-bit counter load (control word + LSB + MSB) and 16-bit latched counter read (latch command + LSB + MSB). It sits between a CPU/testbench sequencer and the timer top level, with a tri-state Data split into data_out/data_oe/data_in.

Parameters:
SETUP_CYC, 1, cycles address/CS/data held before strobe asserts (>=1)
STROBE_CYC, 2, cycles RD_n or WR_n held low (>=1)
HOLD_CYC, 1, cycles address/CS/data held after strobe release (>=1)

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  command request valid
req_ready  out  1  block idle, accepts request this cycle
req_op  in  2  0=WRITE_BYTE, 1=READ_BYTE, 2=LOAD16, 3=LATCH_READ16
req_addr  in  2  {A1,A0} for byte ops; counter select 0..2 for 16-bit ops
req_mode  in  3  counter mode M2..M0 (LOAD16 only)
req_bcd  in  1  BCD bit (LOAD16 only)
req_data  in  16  write byte in [7:0] (WRITE_BYTE) or count value (LOAD16)
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_err  out  1  qualifies rsp_valid: request rejected
rsp_data  out  16  read result
cs_n, rd_n, wr_n  out  1 each  active-low bus strobes
a1, a0  out  1 each  bus address
data_out  out  8  write data to timer bus
data_oe  out  1  drive enable for data_out onto Data
data_in  in  8  Data as seen by the master

Behaviour:
- Reset (sync): cs_n=rd_n=wr_n=1, a1=a0=0, data_out=0, data_oe=0, rsp_valid=0, rsp_err=0, rsp_data=0. req_ready=1 from the first cycle after reset. Reset mid-operation aborts the sequence at the next edge with no response, and all strobes return high.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP, RESP.
- IDLE:
  - req_ready=1.
  - Accept on req_valid&req_ready.
  - If op is LOAD16 or LATCH_READ16 with req_addr==3, go to RESP with rsp_err=1. No bus activity occurs.
- Byte cycle:
  - SETUP for SETUP_CYC cycles: cs_n=0, a1/a0 valid; data_out valid and data_oe=1 for writes only.
  - STROBE for STROBE_CYC cycles: wr_n=0 or rd_n=0.
  - HOLD for HOLD_CYC cycles: strobes high, cs_n=0, address and data held.
- Read sampling: data_in is captured on the last STROBE cycle's edge.
- Multi-byte ops: one GAP cycle between bytes with cs_n=1 and data_oe=0.
- Byte sequences:
  - LOAD16: address 3 with CW={req_addr,2'b11,req_mode,req_bcd}, then req_addr with req_data[7:0], then req_addr with req_data[15:8].
  - LATCH_READ16: address 3 with CW={req_addr,6'b000000}, then read LSB, then read MSB from req_addr.
- RESP (1 cycle):
  - rsp_valid=1.
  - rsp_data: READ_BYTE gives {8'h00,byte}; LATCH_READ16 gives {MSB,LSB}; writes and errors give 0.
  - rsp_err=1 only for rejected requests.
  - Next state is IDLE; req_ready=1 again the following cycle.
- Latency, with B = SETUP_CYC+STROBE_CYC+HOLD_CYC:
  - Single byte op: rsp_valid exactly B+1 cycles after the accept edge.
  - 3-byte op: 3B+2+1 cycles after the accept edge.
  - Defaults give 5 cycles (single byte) and 15 cycles (3-byte).
- Invariants:
  - rd_n and wr_n are never low simultaneously.
  - data_oe is never 1 while rd_n=0.
  - cs_n=1 whenever in IDLE, GAP or RESP.
- req_valid while busy is ignored and held off by req_ready=0. Request fields are registered at accept; later changes have no effect.

Decomposition:
- Package pit_bus_pkg holds:
  - op encoding constants (OP_WR, OP_RD, OP_LOAD16, OP_LATCH16)
  - FSM state enum
  - control-word field constants: ADDR_CWR=2'b11, RW_LATCH=2'b00, RW_LSB_MSB=2'b11
  - helper function building the control-word byte
- Sub-module pit_bus_cycle: single-byte timing engine (SETUP/STROBE/HOLD counters, strobe generation, read capture) driven by a start/done handshake. The top-level sequencer issues 1 or 3 byte cycles.

Test Plan:
- WRITE_BYTE addr=1 data=8'hA5, defaults -> cs_n low cycles 1-4, wr_n low cycles 2-3, data_oe=1 with data_out=A5 cycles 1-4, rsp_valid at cycle 5 with rsp_err=0, rd_n stays high.
- LOAD16 addr=2 mode=3 bcd=0 data=16'h1234 -> bytes 8'hB6 at addr 3, 8'h34 then 8'h12 at addr 2, cs_n=1 during the 2 GAP cycles, rsp_valid at cycle 15.
- LATCH_READ16 addr=0, bench returns data_in=8'h78 then 8'h56 during the respective strobes -> write 8'h00 to addr 3, two reads at addr 0, rsp_data=16'h5678, data_oe=0 during reads.
- LOAD16 with addr=3 -> no cs_n activity, rsp_valid with rsp_err=1 on the cycle after accept, rsp_data=0.
- STROBE_CYC=4 build, READ_BYTE with data_in changing mid-strobe -> captured value equals data_in on the 4th strobe cycle; rsp at cycle 7.
- rst asserted during the STROBE of a LOAD16 second byte -> next cycle all strobes high, data_oe=0, no rsp_valid, req_ready=1 after reset.
